// File: rtl/shift_add_controller.sv
// Sequencing FSM for a shift-and-add multiplier: clears the accumulator once,
// then scans the multiplier LSB-first for N_BITS cycles and pulses done.
module shift_add_controller #(
   parameter int N_BITS = 5,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N_BITS-1:0] multiplier,
   output logic              busy,
   output logic              done,
   output logic              acc_enable,
   output logic [1:0]        acc_s,
   output logic [CNT_W-1:0]  bit_idx
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_EXEC,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BITS - 1);

   state_t              state_q, state_d;
   logic [N_BITS-1:0]   mreg_q, mreg_d;
   logic [CNT_W-1:0]    count_q, count_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         mreg_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         mreg_q  <= mreg_d;
         count_q <= count_d;
      end
   end

   // Outputs depend only on registered state, mreg and count.
   always_comb begin
      state_d    = state_q;
      mreg_d     = mreg_q;
      count_d    = count_q;
      busy       = 1'b0;
      done       = 1'b0;
      acc_enable = 1'b0;
      acc_s      = 2'b00;
      bit_idx    = '0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mreg_d  = multiplier;
               count_d = '0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            busy       = 1'b1;
            acc_enable = 1'b1;
            acc_s      = 2'b01;
            state_d    = S_EXEC;
         end
         S_EXEC: begin
            busy       = 1'b1;
            acc_enable = 1'b1;
            acc_s      = mreg_q[0] ? 2'b10 : 2'b11;
            bit_idx    = count_q;
            mreg_d     = mreg_q >> 1;
            count_d    = count_q + CNT_W'(1);
            if (count_q == LAST_IDX) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_shift_add_controller.sv
// Bench for shift_add_controller: a queue-based timeline model checked every
// cycle, plus directed sequences with hand-written expected values.
module tb_shift_add_controller;

   localparam int N_BITS = 5;
   localparam int CNT_W  = 3;

   logic              clk;
   logic              rst;
   logic              start;
   logic [N_BITS-1:0] multiplier;
   logic              busy;
   logic              done;
   logic              acc_enable;
   logic [1:0]        acc_s;
   logic [CNT_W-1:0]  bit_idx;

   int n_checks = 0;
   int n_fail   = 0;

   shift_add_controller #(.N_BITS(N_BITS), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .multiplier (multiplier),
      .busy       (busy),
      .done       (done),
      .acc_enable (acc_enable),
      .acc_s      (acc_s),
      .bit_idx    (bit_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic             busy;
      logic             done;
      logic             en;
      logic [1:0]       s;
      logic [CNT_W-1:0] idx;
   } exp_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   // Model: each accepted operation becomes a timeline of expected outputs,
   // one entry per cycle; an empty timeline means the controller is idle.
   exp_t timeline[$];

   initial begin
      exp_t want;
      exp_t got;
      exp_t e;
      @(posedge clk);
      forever begin
         @(negedge clk);
         want = (timeline.size() > 0) ? timeline[0] : exp_t'(0);
         got  = {busy, done, acc_enable, acc_s, bit_idx};
         check("model_cycle", 32'(got), 32'(want));
         if (rst) begin
            timeline.delete();
         end else if (timeline.size() > 0) begin
            void'(timeline.pop_front());
         end else if (start) begin
            e = '{busy: 1'b1, done: 1'b0, en: 1'b1, s: 2'b01, idx: '0};
            timeline.push_back(e);
            for (int i = 0; i < N_BITS; i++) begin
               e = '{busy: 1'b1, done: 1'b0, en: 1'b1,
                     s: multiplier[i] ? 2'b10 : 2'b11, idx: CNT_W'(i)};
               timeline.push_back(e);
            end
            e = '{busy: 1'b0, done: 1'b1, en: 1'b0, s: 2'b00, idx: '0};
            timeline.push_back(e);
         end
      end
   end

   // Runs one operation from IDLE; s_seq lists acc_s for cycles 1..7, MSB first.
   // With inject set, a start with a different multiplier is offered in cycle 3.
   task automatic directed(input logic [4:0] m, input logic [13:0] s_seq,
                           input bit inject, input string tag);
      start      = 1'b1;
      multiplier = m;
      @(posedge clk); #1;
      for (int c = 1; c <= 7; c++) begin
         start      = (inject && c == 3);
         multiplier = inject ? ~m : 5'($urandom);
         @(negedge clk); #2;
         check({tag, "_acc_s"}, 32'(acc_s), 32'(s_seq[(7-c)*2 +: 2]));
         check({tag, "_done"}, 32'(done), 32'(c == 7));
         if (c >= 2 && c <= 6) begin
            check({tag, "_bit_idx"}, 32'(bit_idx), 32'(c - 2));
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b1;
      multiplier = 5'b10101;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk); #2;
      check("reset_busy", 32'(busy), 32'(0));
      check("reset_acc_s", 32'(acc_s), 32'(0));
      check("reset_bit_idx", 32'(bit_idx), 32'(0));
      @(posedge clk); #1;
      rst   = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      directed(5'b10110, 14'b01_11_10_10_11_10_00, 1'b0, "m10110");
      directed(5'b00000, 14'b01_11_11_11_11_11_00, 1'b0, "m00000");
      directed(5'b11111, 14'b01_10_10_10_10_10_00, 1'b0, "m11111");
      directed(5'b10110, 14'b01_11_10_10_11_10_00, 1'b1, "ignore_start");

      // Reset in the third EXEC cycle (cycle 4) aborts without done.
      start      = 1'b1;
      multiplier = 5'b11111;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #2;
      check("abort_busy", 32'(busy), 32'(0));
      check("abort_done", 32'(done), 32'(0));
      check("abort_enable", 32'(acc_enable), 32'(0));
      @(posedge clk); #1;
      directed(5'b01001, 14'b01_10_11_11_10_11_00, 1'b0, "after_rst");

      // Held start gives back-to-back operations with one idle cycle between.
      start      = 1'b1;
      multiplier = 5'b00110;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         @(negedge clk); #2;
         check("held_done", 32'(done), 32'(c == 7 || c == 15));
         if (c == 8 || c == 16) begin
            check("held_idle_busy", 32'(busy), 32'(0));
            check("held_idle_enable", 32'(acc_enable), 32'(0));
         end
      end
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;

      // Random traffic, checked cycle-by-cycle against the timeline model.
      for (int i = 0; i < 400; i++) begin
         rst        = ($urandom_range(0, 39) == 0);
         start      = ($urandom_range(0, 3) == 0);
         multiplier = 5'($urandom);
         @(posedge clk); #1;
      end
      rst   = 1'b0;
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk); #2;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
